ps2_mouse_rx: RTL

- Upstream of the Mechatronics mouse / joystick-emulation stage.
- Receives the raw PS/2 mouse serial stream (device-to-host only) and frames 11-bit characters.
- Assembles standard 3-byte movement packets and publishes them as the 25-bit ps2_mouse word.
- Word format: [24] toggle strobe, [23:16] Y delta, [15:8] X delta, [7:0] status byte.
- Lets the core run from a physical PS/2 mouse instead of the HPS-supplied word.

---
 rtl/ps2_mouse_pkg.sv | 23 ++
 rtl/ps2_rx_byte.sv | 139 +++++++++++++
 rtl/ps2_mouse_rx.sv | 102 ++++++++++
 3 files changed

// File: rtl/ps2_mouse_pkg.sv
// rtl/ps2_mouse_pkg.sv - shared state type, status bit and word field positions for the PS/2 mouse receiver
package ps2_mouse_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} byte_state_e;

  localparam int BTN_L   = 0;
  localparam int BTN_R   = 1;
  localparam int BTN_M   = 2;
  localparam int ALWAYS1 = 3;
  localparam int XSIGN   = 4;
  localparam int YSIGN   = 5;
  localparam int XOVF    = 6;
  localparam int YOVF    = 7;

  localparam int STB   = 24;
  localparam int Y_LSB = 16;
  localparam int X_LSB = 8;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// rtl/ps2_rx_byte.sv - PS/2 line synchronisers, clock glitch filter, 11-bit frame FSM and inactivity timeout
// PS2_PARITY_CHK_EN: when defined, bytes failing odd parity are reported as frame errors
module ps2_rx_byte
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 21477272,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  input  logic       pkt_busy,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       timeout
);

  localparam longint unsigned TO_CYC_L = 64'(TIMEOUT_US) * 64'(CLK_HZ) / 64'd1_000_000;
  localparam int unsigned TO_CYC = 32'(TO_CYC_L);
  localparam int TO_W   = $clog2(TO_CYC + 1);
  localparam int FILT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]        clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic              filt_clk_q, filt_clk_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  byte_state_e       state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              byte_valid_q, byte_valid_d, frame_err_q, frame_err_d, timeout_q, timeout_d;
  logic              smp_stb, to_hit, dat;

  assign dat = dat_sync_q[1];

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk_i};
    dat_sync_d = {dat_sync_q[0], ps2_dat_i};
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    smp_stb    = 1'b0;
    if (clk_sync_q[1] != filt_clk_q) begin
      if (filt_cnt_q == FILT_W'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_sync_q[1];
        smp_stb    = filt_clk_q;  // only the high-to-low transition samples data
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end

    to_hit   = 1'b0;
    to_cnt_d = to_cnt_q;
    if (smp_stb || (state_q == IDLE && !pkt_busy)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
      to_cnt_d = '0;
      to_hit   = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    timeout_d    = to_hit;
    if (to_hit) begin
      state_d = IDLE;
    end else if (smp_stb) begin
      case (state_q)
        IDLE: begin
          if (!dat) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d = {dat, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = PARITY;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: begin
          par_d   = dat;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat) frame_err_d = 1'b1;
`ifdef PS2_PARITY_CHK_EN
          else if (!odd_parity_ok(shift_q, par_q)) frame_err_d = 1'b1;
`endif
          else byte_valid_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q   <= 2'b11;
      dat_sync_q   <= 2'b11;
      filt_clk_q   <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      clk_sync_q   <= clk_sync_d;
      dat_sync_q   <= dat_sync_d;
      filt_clk_q   <= filt_clk_d;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign rx_byte    = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign timeout    = timeout_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// rtl/ps2_mouse_rx.sv - PS/2 mouse receiver top: 3-byte packet assembler and saturating error counter
// PS2_PARITY_CHK_EN (in ps2_rx_byte) adds odd-parity rejection of received bytes
module ps2_mouse_rx
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 21477272,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk_i,
  input  logic        ps2_dat_i,
  output logic [24:0] ps2_mouse,
  output logic        pkt_err,
  output logic [7:0]  err_cnt
);

  logic [7:0]  rx_byte;
  logic        byte_valid, frame_err, timeout;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  b0_q, b0_d, b1_q, b1_d;
  logic [24:0] mouse_q, mouse_d;
  logic        pkt_err_q, pkt_err_d, err;
  logic [7:0]  err_cnt_q, err_cnt_d;

  ps2_rx_byte #(
    .CLK_HZ    (CLK_HZ),
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_US(TIMEOUT_US)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk_i (ps2_clk_i),
    .ps2_dat_i (ps2_dat_i),
    .pkt_busy  (idx_q != 2'd0),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err),
    .timeout   (timeout)
  );

  always_comb begin
    idx_d   = idx_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    mouse_d = mouse_q;
    err     = 1'b0;
    if (timeout || frame_err) begin
      idx_d = 2'd0;
      err   = 1'b1;
    end else if (byte_valid) begin
      case (idx_q)
        2'd0: begin
          // bit3 is always set in a status byte; anything else means we are out of step
          if (rx_byte[ALWAYS1]) begin
            b0_d  = rx_byte;
            idx_d = 2'd1;
          end else begin
            err = 1'b1;
          end
        end
        2'd1: begin
          b1_d  = rx_byte;
          idx_d = 2'd2;
        end
        default: begin
          mouse_d[STB]         = ~mouse_q[STB];
          mouse_d[Y_LSB +: 8]  = rx_byte;
          mouse_d[X_LSB +: 8]  = b1_q;
          mouse_d[7:0]         = b0_q;
          idx_d                = 2'd0;
        end
      endcase
    end
    pkt_err_d = err;
    err_cnt_d = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q     <= 2'd0;
      b0_q      <= '0;
      b1_q      <= '0;
      mouse_q   <= '0;
      pkt_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      idx_q     <= idx_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      mouse_q   <= mouse_d;
      pkt_err_q <= pkt_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ps2_mouse = mouse_q;
  assign pkt_err   = pkt_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
